// File: rtl/axis_pair_packer.sv
// Packs a one-word-per-beat AXI-Stream into two-word beats with a 2-bit keep mask.
// An odd-length packet ends with a half-empty beat (keep=01, unused lane zeroed).
module axis_pair_packer #(
    parameter int unsigned WORD_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     i_tdata,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [2*WORD_W-1:0]   o_tdata,
    output logic [1:0]            o_tkeep,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready
);

    localparam int unsigned OUT_W = 2 * WORD_W;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_hold;
    logic [OUT_W-1:0]    r_tdata;
    logic [1:0]          r_tkeep;
    logic                r_tlast;
    logic                r_tvalid;

    logic                w_in_hs;
    logic                w_out_hs;

    // Place the first word of a pair in the lane selected by BIG_ENDIAN.
    function automatic logic [OUT_W-1:0] f_pack(input logic [WORD_W-1:0] first,
                                                 input logic [WORD_W-1:0] second);
        if (BIG_ENDIAN)
            f_pack = {first, second};
        else
            f_pack = {second, first};
    endfunction

    // Ready depends only on the output register, never on the input side.
    assign i_tready = !r_tvalid || o_tready;
    assign w_in_hs  = i_tvalid && i_tready;
    assign w_out_hs = r_tvalid && o_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_hold   <= '0;
            r_tdata  <= '0;
            r_tkeep  <= 2'b00;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            if (w_out_hs) begin
                r_tvalid <= 1'b0;
            end
            if (w_in_hs) begin
                case (r_state)
                    ST_EMPTY: begin
                        if (i_tlast) begin
                            r_tdata  <= f_pack(i_tdata, WORD_W'(0));
                            r_tkeep  <= 2'b01;
                            r_tlast  <= 1'b1;
                            r_tvalid <= 1'b1;
                        end else begin
                            r_hold   <= i_tdata;
                            r_state  <= ST_HALF;
                        end
                    end
                    ST_HALF: begin
                        r_tdata  <= f_pack(r_hold, i_tdata);
                        r_tkeep  <= 2'b11;
                        r_tlast  <= i_tlast;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_EMPTY;
                    end
                    default: begin
                        r_state  <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    assign o_tdata  = r_tdata;
    assign o_tkeep  = r_tkeep;
    assign o_tlast  = r_tlast;
    assign o_tvalid = r_tvalid;

endmodule

// File: tb/tb_axis_pair_packer.sv
// Scoreboard bench for axis_pair_packer: one little-endian and one big-endian
// instance share stimulus; a packet-level reference model predicts every beat.
module tb_axis_pair_packer;

    localparam int unsigned WORD_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [WORD_W-1:0] i_tdata;
    logic              i_tlast;
    logic              i_tvalid;
    logic              o_tready;

    logic              le_i_tready, be_i_tready;
    logic [63:0]       le_tdata, be_tdata;
    logic [1:0]        le_tkeep, be_tkeep;
    logic              le_tlast, be_tlast;
    logic              le_tvalid, be_tvalid;

    axis_pair_packer #(.WORD_W(WORD_W), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(le_i_tready),
        .o_tdata(le_tdata), .o_tkeep(le_tkeep), .o_tlast(le_tlast), .o_tvalid(le_tvalid),
        .o_tready(o_tready)
    );

    axis_pair_packer #(.WORD_W(WORD_W), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(be_i_tready),
        .o_tdata(be_tdata), .o_tkeep(be_tkeep), .o_tlast(be_tlast), .o_tvalid(be_tvalid),
        .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d_le;
        logic [63:0] d_be;
        logic [1:0]  keep;
        logic        last;
        int          cyc;
        bit          strict;
    } beat_t;

    beat_t             exp_q[$];
    logic [WORD_W-1:0] cur_pkt[$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  rnd_ready = 1'b0;
    bit  tp_phase = 1'b0;
    int  tp_beats = 0;
    int  tp_ready_low = 0;
    int  tp_last_cyc = 0;

    bit          prev_stall = 1'b0;
    logic [63:0] stall_le, stall_be;
    logic [1:0]  stall_keep;
    logic        stall_last;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: collect words per packet; a beat closes at two words or at tlast.
    task automatic model_accept(input logic [WORD_W-1:0] d, input logic l);
        beat_t       b;
        logic [WORD_W-1:0] first, second;
        cur_pkt.push_back(d);
        if (cur_pkt.size() == 2 || l) begin
            first    = cur_pkt[0];
            second   = (cur_pkt.size() == 2) ? cur_pkt[1] : '0;
            b.d_le   = {second, first};
            b.d_be   = {first, second};
            b.keep   = (cur_pkt.size() == 2) ? 2'b11 : 2'b01;
            b.last   = l;
            b.cyc    = cyc;
            b.strict = !rnd_ready;
            exp_q.push_back(b);
            cur_pkt.delete();
        end
    endtask

    task automatic model_reset();
        cur_pkt.delete();
        exp_q.delete();
    endtask

    // Offer one word until accepted; rnd inserts idle cycles with garbage payload.
    task automatic send_word(input logic [WORD_W-1:0] d, input logic l, input bit rnd);
        int n = 0;
        forever begin
            @(negedge clk);
            if (rnd && $urandom_range(0, 2) == 0) begin
                i_tvalid = 1'b0;
                i_tdata  = $urandom;
                i_tlast  = 1'($urandom_range(0, 1));
            end else begin
                i_tvalid = 1'b1;
                i_tdata  = d;
                i_tlast  = l;
            end
            #2;
            if (i_tvalid && le_i_tready) begin
                model_accept(d, l);
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: word 0x%0h not accepted within 200 cycles", d);
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_tvalid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        i_tvalid = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every output handshake and polices stalls.
    always @(negedge clk) begin
        beat_t b;
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("lanes_agree", {le_tvalid, le_i_tready, le_tkeep, le_tlast},
                                 {be_tvalid, be_i_tready, be_tkeep, be_tlast});
            if (le_tvalid && !o_tready) begin
                check("stall_i_tready", 64'(le_i_tready), 64'd0);
            end
            if (prev_stall) begin
                check("stall_stable", {le_tvalid, le_tdata, le_tkeep, le_tlast},
                                      {1'b1, stall_le, stall_keep, stall_last});
                check("stall_stable_be", be_tdata, stall_be);
            end
            if (tp_phase && !le_i_tready) tp_ready_low++;
            if (le_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h keep %b with nothing expected",
                             le_tdata, le_tkeep);
                end else begin
                    b = exp_q.pop_front();
                    check("tdata_le", le_tdata, b.d_le);
                    check("tdata_be", be_tdata, b.d_be);
                    check("tkeep", 64'(le_tkeep), 64'(b.keep));
                    check("tlast", 64'(le_tlast), 64'(b.last));
                    if (b.strict) check("latency", 64'(cyc), 64'(b.cyc + 1));
                end
                if (tp_phase) begin
                    if (tp_beats > 0) check("tp_spacing", 64'(cyc - tp_last_cyc), 64'd2);
                    tp_beats++;
                    tp_last_cyc = cyc;
                end
            end
            prev_stall = le_tvalid && !o_tready;
            stall_le   = le_tdata;
            stall_be   = be_tdata;
            stall_keep = le_tkeep;
            stall_last = le_tlast;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lens[3];
        rst      = 1'b1;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        o_tready = 1'b1;

        // Reset and idle.
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_tvalid", 64'(le_tvalid), 64'd0);
        check("rst_tkeep", 64'(le_tkeep), 64'd0);
        check("rst_tdata", le_tdata, 64'd0);
        check("rst_tlast", 64'(le_tlast), 64'd0);
        check("rst_i_tready", 64'(le_i_tready), 64'd1);

        // Even packet, then odd packet, then a one-word packet.
        send_word(32'h11, 1'b0, 1'b0);
        send_word(32'h22, 1'b0, 1'b0);
        send_word(32'h33, 1'b0, 1'b0);
        send_word(32'h44, 1'b1, 1'b0);
        send_word(32'hA, 1'b0, 1'b0);
        send_word(32'hB, 1'b0, 1'b0);
        send_word(32'hC, 1'b1, 1'b0);
        send_word(32'hD, 1'b1, 1'b0);
        drain();

        // Random backpressure: packets of 5, 1 and 10 words.
        lens[0] = 5; lens[1] = 1; lens[2] = 10;
        rnd_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int w = 0; w < lens[p]; w++) begin
                send_word($urandom, 1'(w == lens[p] - 1), 1'b1);
            end
        end
        rnd_ready = 1'b0;
        drain();

        // Sustained throughput on a 64-word packet.
        idle_cycles(2);
        tp_phase = 1'b1;
        for (int w = 0; w < 64; w++) begin
            send_word($urandom, 1'(w == 63), 1'b0);
        end
        drain();
        idle_cycles(1);
        tp_phase = 1'b0;
        check("tp_beats", 64'(tp_beats), 64'd32);
        check("tp_ready_low", 64'(tp_ready_low), 64'd0);

        // Reset while a word is held: it must vanish.
        send_word(32'h55, 1'b0, 1'b0);
        @(negedge clk);
        i_tvalid = 1'b0;
        rst      = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("midrst_tvalid", 64'(le_tvalid), 64'd0);
        send_word(32'h66, 1'b1, 1'b0);
        drain();

        idle_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
